ttt_board_nxn: RTL and testbench

Parametrised successor to the 3×3 tic-tac-toe controller. It plays an N×N board for two players with a win condition of N marks in a row, column or diagonal. Inputs are a level-sampled cursor-advance button and a place button, each acted on at its rising edge. A per-turn timeout auto-places the mark at the cursor. The block sits between the debounced button inputs and the board display/VGA renderer, and exports the flattened board, the cursor, the player on turn and the result.

---
 rtl/ttt_pkg.sv | 52 +++++
 rtl/ttt_line_check.sv | 49 ++++
 rtl/ttt_board_nxn.sv | 151 +++++++++++++++
 tb/tb_ttt_board_nxn.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ttt_pkg : shared types and free-cell search for ttt_board_nxn        |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
package ttt_pkg;

   localparam int MAX_NC = 25;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      P1    = 2'b01,
      P2    = 2'b10
   } cell_t;

   typedef enum logic [1:0] {
      NONE   = 2'b00,
      WIN_P1 = 2'b01,
      WIN_P2 = 2'b10,
      DRAW   = 2'b11
   } result_t;

   typedef enum logic [1:0] {
      PLAY  = 2'd0,
      CHECK = 2'd1,
      DONE  = 2'd2
   } state_t;

   // First EMPTY cell strictly above idx, wrapping; returns idx itself if it is the only one left.
   function automatic logic [4:0] next_free(input logic [2*MAX_NC-1:0] b,
                                            input int nc,
                                            input int idx);
      logic       found;
      int         k;
      logic [4:0] res;
      found = 1'b0;
      res   = idx[4:0];
      for (int off = 1; off <= MAX_NC; off++) begin
         if (!found && off <= nc) begin
            k = idx + off;
            if (k >= nc) k = k - nc;
            if (b[2*k +: 2] == EMPTY) begin
               found = 1'b1;
               res   = k[4:0];
            end
         end
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ttt_line_check.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ttt_line_check : flags an N-in-line (rows, columns, diagonals)       |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
module ttt_line_check
   import ttt_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [2*N*N-1:0] board,
   input  logic [1:0]       player,
   output logic             win
);

   localparam int NC = N*N;

   logic [NC-1:0] hit;
   logic          row_ok;
   logic          col_ok;
   logic          diag_ok;
   logic          anti_ok;

   for (genvar k = 0; k < NC; k++) begin : g_hit
      assign hit[k] = (board[2*k +: 2] == player);
   end

   always_comb begin
      win     = 1'b0;
      row_ok  = 1'b1;
      col_ok  = 1'b1;
      diag_ok = 1'b1;
      anti_ok = 1'b1;
      for (int i = 0; i < N; i++) begin
         row_ok = 1'b1;
         col_ok = 1'b1;
         for (int j = 0; j < N; j++) begin
            row_ok = row_ok & hit[i*N + j];
            col_ok = col_ok & hit[j*N + i];
         end
         diag_ok = diag_ok & hit[i*N + i];
         anti_ok = anti_ok & hit[i*N + (N-1-i)];
         win     = win | row_ok | col_ok;
      end
      win = win | diag_ok | anti_ok;
   end

endmodule
`default_nettype wire

// File: rtl/ttt_board_nxn.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ttt_board_nxn : N x N tic-tac-toe controller with per-turn timeout   |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
module ttt_board_nxn
   import ttt_pkg::*;
#(
   parameter int N            = 3,
   parameter int TURN_TIMEOUT = 50_000_000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    sel,
   input  logic                    next,
   input  logic                    restart,
   output logic [2*N*N-1:0]        board,
   output logic [$clog2(N*N)-1:0]  position_out,
   output logic                    turn,
   output logic [1:0]              winner,
   output logic                    game_over,
   output logic                    timeout
);

   localparam int NC = N*N;
   localparam int PW = $clog2(NC);
   localparam int TW = $clog2(TURN_TIMEOUT);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TURN_TIMEOUT - 1);

   state_t          state, state_n;
   logic            sel_q, next_q, restart_q;
   logic [TW-1:0]   timer, timer_n;
   logic            starter, starter_n;
   logic [2*NC-1:0] board_n;
   logic [PW-1:0]   pos_n;
   logic            turn_n;
   logic [1:0]      winner_n;
   logic            timeout_n;

   logic                sel_edge, next_edge, restart_edge;
   logic [1:0]          mover;
   logic                line_win;
   logic                any_empty;
   logic [2*MAX_NC-1:0] board_pad;
   logic [PW-1:0]       free_pos;

   assign sel_edge     = sel & ~sel_q;
   assign next_edge    = next & ~next_q;
   assign restart_edge = restart & ~restart_q;
   assign mover        = turn ? P2 : P1;

   always_comb begin
      board_pad           = '0;
      board_pad[2*NC-1:0] = board;
      any_empty           = 1'b0;
      for (int k = 0; k < NC; k++) begin
         if (board[2*k +: 2] == EMPTY) any_empty = 1'b1;
      end
   end

   // Same search serves the next button and the post-move cursor hop.
   assign free_pos = PW'(next_free(board_pad, NC, int'(position_out)));

   ttt_line_check #(.N(N)) u_line_check (
      .board  (board),
      .player (mover),
      .win    (line_win)
   );

   always_comb begin
      state_n   = state;
      board_n   = board;
      pos_n     = position_out;
      turn_n    = turn;
      winner_n  = winner;
      timer_n   = timer;
      starter_n = starter;
      timeout_n = 1'b0;
      if (restart_edge) begin
         board_n   = '0;
         pos_n     = '0;
         turn_n    = ~starter;
         starter_n = ~starter;
         winner_n  = NONE;
         timer_n   = '0;
         state_n   = PLAY;
      end else begin
         case (state)
            PLAY: begin
               if (sel_edge || timer == TIMER_LAST) begin
                  board_n[2*position_out +: 2] = mover;
                  timer_n   = '0;
                  timeout_n = ~sel_edge;
                  state_n   = CHECK;
               end else if (next_edge) begin
                  pos_n = free_pos;
               end else begin
                  timer_n = timer + 1'b1;
               end
            end
            CHECK: begin
               if (line_win) begin
                  winner_n = turn ? WIN_P2 : WIN_P1;
                  state_n  = DONE;
               end else if (!any_empty) begin
                  winner_n = DRAW;
                  state_n  = DONE;
               end else begin
                  turn_n  = ~turn;
                  pos_n   = free_pos;
                  state_n = PLAY;
               end
            end
            DONE:    state_n = DONE;
            default: state_n = PLAY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= PLAY;
         sel_q        <= 1'b0;
         next_q       <= 1'b0;
         restart_q    <= 1'b0;
         timer        <= '0;
         starter      <= 1'b0;
         board        <= '0;
         position_out <= '0;
         turn         <= 1'b0;
         winner       <= NONE;
         game_over    <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         state        <= state_n;
         sel_q        <= sel;
         next_q       <= next;
         restart_q    <= restart;
         timer        <= timer_n;
         starter      <= starter_n;
         board        <= board_n;
         position_out <= pos_n;
         turn         <= turn_n;
         winner       <= winner_n;
         game_over    <= (state_n == DONE);
         timeout      <= timeout_n;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ttt_board_nxn.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ttt_board_nxn : directed self-checking bench for ttt_board_nxn    |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_ttt_board_nxn;

   logic clk;
   logic rst;
   logic sel, next, restart;
   logic [1:0] act;
   int checks   = 0;
   int failures = 0;

   logic        a_sel, a_next, a_restart, a_turn, a_go, a_to;
   logic [17:0] a_board;
   logic [3:0]  a_pos;
   logic [1:0]  a_winner;

   logic        t_sel, t_next, t_restart, t_turn, t_go, t_to;
   logic [17:0] t_board;
   logic [3:0]  t_pos;
   logic [1:0]  t_winner;

   logic        f_sel, f_next, f_restart, f_turn, f_go, f_to;
   logic [31:0] f_board;
   logic [3:0]  f_pos;
   logic [1:0]  f_winner;

   logic [31:0] cur_board;
   logic [3:0]  cur_pos;

   // Shared buttons are steered to the instance under test.
   assign a_sel = sel & (act == 2'd0);  assign a_next = next & (act == 2'd0);  assign a_restart = restart & (act == 2'd0);
   assign t_sel = sel & (act == 2'd1);  assign t_next = next & (act == 2'd1);  assign t_restart = restart & (act == 2'd1);
   assign f_sel = sel & (act == 2'd2);  assign f_next = next & (act == 2'd2);  assign f_restart = restart & (act == 2'd2);

   always_comb begin
      cur_board = '0;
      cur_pos   = '0;
      case (act)
         2'd0:    begin cur_board[17:0] = a_board; cur_pos = a_pos; end
         2'd1:    begin cur_board[17:0] = t_board; cur_pos = t_pos; end
         default: begin cur_board = f_board;       cur_pos = f_pos; end
      endcase
   end

   ttt_board_nxn #(.N(3), .TURN_TIMEOUT(1000)) dut_a (
      .clk(clk), .rst(rst), .sel(a_sel), .next(a_next), .restart(a_restart),
      .board(a_board), .position_out(a_pos), .turn(a_turn), .winner(a_winner),
      .game_over(a_go), .timeout(a_to));

   ttt_board_nxn #(.N(3), .TURN_TIMEOUT(16)) dut_t (
      .clk(clk), .rst(rst), .sel(t_sel), .next(t_next), .restart(t_restart),
      .board(t_board), .position_out(t_pos), .turn(t_turn), .winner(t_winner),
      .game_over(t_go), .timeout(t_to));

   ttt_board_nxn #(.N(4), .TURN_TIMEOUT(1000)) dut_f (
      .clk(clk), .rst(rst), .sel(f_sel), .next(f_next), .restart(f_restart),
      .board(f_board), .position_out(f_pos), .turn(f_turn), .winner(f_winner),
      .game_over(f_go), .timeout(f_to));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic press_sel;
      sel = 1'b1; tick; sel = 1'b0; tick;
   endtask

   task automatic press_next;
      next = 1'b1; tick; next = 1'b0; tick;
   endtask

   task automatic goto(input int target);
      int n;
      n = 0;
      while (int'(cur_pos) != target && n < 20) begin
         press_next;
         n++;
      end
      chk("goto", 64'(cur_pos), 64'(target));
   endtask

   task automatic place(input int target);
      goto(target);
      press_sel;
   endtask

   initial begin
      rst = 1'b0; sel = 1'b0; next = 1'b0; restart = 1'b0; act = 2'd0;

      // Reset and held sel
      tick; tick;
      chk("rst_board",  64'(a_board),  64'h0);
      chk("rst_pos",    64'(a_pos),    64'h0);
      chk("rst_turn",   64'(a_turn),   64'h0);
      chk("rst_winner", 64'(a_winner), 64'h0);
      chk("rst_go",     64'(a_go),     64'h0);
      chk("rst_to",     64'(a_to),     64'h0);
      chk("rst_board4", 64'(f_board),  64'h0);
      rst = 1'b1;
      sel = 1'b1; tick; tick; tick; tick;
      chk("hold_board", 64'(a_board), 64'h1);
      chk("hold_turn",  64'(a_turn),  64'h1);
      chk("hold_pos",   64'(a_pos),   64'h1);
      chk("hold_go",    64'(a_go),    64'h0);
      sel = 1'b0; tick;

      // Row win for P1 on cells 0,1,2
      rst = 1'b0; tick; rst = 1'b1;
      place(0); place(3); place(1); place(4);
      goto(2);
      sel = 1'b1; tick;
      chk("row_board",   64'(a_board), 64'h295);
      chk("row_go_early", 64'(a_go),   64'h0);
      sel = 1'b0; tick;
      chk("row_winner", 64'(a_winner), 64'h1);
      chk("row_go",     64'(a_go),     64'h1);
      chk("row_turn",   64'(a_turn),   64'h0);
      press_sel; press_next;
      chk("done_board", 64'(a_board), 64'h295);
      chk("done_pos",   64'(a_pos),   64'h2);

      // Draw
      rst = 1'b0; tick; rst = 1'b1;
      place(0); place(2); place(1); place(3); place(5);
      place(4); place(6); place(7); place(8);
      chk("draw_board",  64'(a_board),  64'h196A5);
      chk("draw_winner", 64'(a_winner), 64'h3);
      chk("draw_go",     64'(a_go),     64'h1);

      // Cursor wrap past occupied 7,8; simultaneous sel+next
      rst = 1'b0; tick; rst = 1'b1;
      place(7);
      chk("skip_pos8", 64'(a_pos), 64'h8);
      press_sel;
      chk("wrap_after_check", 64'(a_pos), 64'h0);
      goto(6);
      press_next;
      chk("wrap_pos", 64'(a_pos), 64'h0);
      sel = 1'b1; next = 1'b1; tick;
      chk("both_board", 64'(a_board), 64'h24001);
      chk("both_pos",   64'(a_pos),   64'h0);
      sel = 1'b0; next = 1'b0; tick;
      chk("both_pos_after", 64'(a_pos),  64'h1);
      chk("both_turn",      64'(a_turn), 64'h1);

      // Timeout with TURN_TIMEOUT = 16
      act = 2'd1;
      rst = 1'b0; tick; rst = 1'b1;
      repeat (15) tick;
      chk("to_early",       64'(t_to),    64'h0);
      chk("to_early_board", 64'(t_board), 64'h0);
      tick;
      chk("to_pulse", 64'(t_to),    64'h1);
      chk("to_board", 64'(t_board), 64'h1);
      tick;
      chk("to_pulse_end", 64'(t_to),   64'h0);
      chk("to_turn",      64'(t_turn), 64'h1);
      chk("to_pos",       64'(t_pos),  64'h1);
      repeat (15) tick;
      chk("to2_early", 64'(t_to), 64'h0);
      tick;
      chk("to2_pulse", 64'(t_to),    64'h1);
      chk("to2_board", 64'(t_board), 64'h9);

      // N=4 anti-diagonal, restart, reset mid-CHECK
      act = 2'd2;
      rst = 1'b0; tick; rst = 1'b1;
      place(3); place(0); place(6); place(1); place(9); place(2); place(12);
      chk("diag_board",  64'(f_board),  64'h104106A);
      chk("diag_winner", 64'(f_winner), 64'h1);
      chk("diag_go",     64'(f_go),     64'h1);
      restart = 1'b1; tick;
      chk("rs_board",  64'(f_board),  64'h0);
      chk("rs_turn",   64'(f_turn),   64'h1);
      chk("rs_winner", 64'(f_winner), 64'h0);
      chk("rs_go",     64'(f_go),     64'h0);
      chk("rs_pos",    64'(f_pos),    64'h0);
      restart = 1'b0; tick;
      sel = 1'b1; tick;
      chk("mid_board", 64'(f_board), 64'h2);
      rst = 1'b0; sel = 1'b0; tick; rst = 1'b1;
      chk("mid_rst_board",  64'(f_board),  64'h0);
      chk("mid_rst_pos",    64'(f_pos),    64'h0);
      chk("mid_rst_turn",   64'(f_turn),   64'h0);
      chk("mid_rst_winner", 64'(f_winner), 64'h0);
      chk("mid_rst_go",     64'(f_go),     64'h0);
      tick;
      chk("post_rst_winner", 64'(f_winner), 64'h0);
      chk("post_rst_pos",    64'(f_pos),    64'h0);
      press_next;
      chk("post_rst_next", 64'(f_pos), 64'h1);
      restart = 1'b1; tick;
      chk("post_rst_restart_turn", 64'(f_turn), 64'h1);
      restart = 1'b0; tick;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
